vram_text_scheduler: RTL

- Schedules the single-port video RAM between the 80x25 text-mode fetch engine and the CPU.
- During each 8-pixel character cell it fetches the character byte, attribute byte and font row one cell ahead of the beam. Remaining slots go to a CPU request/acknowledge port.
- Sits between the CPU bus, the VRAM macro, and the VGA adapter that consumes the cell data and supplies the beam counters.

---
 rtl/vga_text_pkg.sv | 42 ++++
 rtl/text_addr_gen.sv | 42 ++++
 rtl/vram_text_scheduler.sv | 136 +++++++++++++
 3 files changed

// File: rtl/vga_text_pkg.sv
// Shared timing, memory-map and fetch-phase definitions for the 80x25 text-mode path.
package vga_text_pkg;

    localparam int unsigned HZB = 48;
    localparam int unsigned HZV = 640;
    localparam int unsigned HZF = 16;
    localparam int unsigned HZS = 96;
    localparam int unsigned HZW = 800;

    localparam int unsigned VTB = 35;
    localparam int unsigned VTV = 400;
    localparam int unsigned VTF = 12;
    localparam int unsigned VTS = 2;
    localparam int unsigned VTW = 449;

    localparam int unsigned COLS = 80;
    localparam int unsigned ROWS = 25;
    localparam logic [15:0] TEXT_BASE = 16'h0000;
    localparam logic [15:0] FONT_BASE = 16'h1000;

    // Fetch runs one cell ahead of the beam.
    localparam int unsigned FETCH_X0 = HZB - 8;
    localparam int unsigned FETCH_X1 = HZB + HZV - 9;
    localparam int unsigned FETCH_Y1 = VTB + VTV - 1;

    typedef enum logic [2:0] {
        PH_CHAR  = 3'd0,
        PH_ATTR  = 3'd1,
        PH_FONT  = 3'd2,
        PH_LATCH = 3'd3,
        PH_CPU0  = 3'd4,
        PH_CPU1  = 3'd5,
        PH_CPU2  = 3'd6,
        PH_CPU3  = 3'd7
    } fetch_phase_e;

    // Phases 4..7 of a cell and every cycle outside the window belong to the CPU.
    function automatic logic cpu_slot(input logic in_win, input logic [2:0] phase);
        return !in_win || phase[2];
    endfunction

endpackage

// File: rtl/text_addr_gen.sv
// Decodes the fetch window, cell phase and VRAM addresses for the cycle after the current beam X.
module text_addr_gen
    import vga_text_pkg::*;
(
    input  logic [9:0]  x_i,
    input  logic [9:0]  y_i,
    input  logic [7:0]  char_i,
    output logic        in_win_o,
    output logic [2:0]  phase_o,
    output logic [15:0] char_addr_o,
    output logic [15:0] font_addr_o
);

    logic [10:0] xn;
    logic [9:0]  xoff;
    logic [9:0]  yy;
    logic [6:0]  col;
    logic [5:0]  crow;
    logic [3:0]  frow;
    logic [14:0] cell_idx;
    logic        in_x;
    logic        in_y;

    // VRAM_ADDR is registered, so decode the beam position of the next cycle.
    assign xn   = {1'b0, x_i} + 11'd1;
    assign in_x = (xn >= 11'(FETCH_X0)) && (xn <= 11'(FETCH_X1));
    assign in_y = (y_i >= 10'(VTB)) && (y_i <= 10'(FETCH_Y1));
    assign xoff = xn[9:0] - 10'(FETCH_X0);
    assign yy   = y_i - 10'(VTB);

    assign phase_o  = xoff[2:0];
    assign col      = xoff[9:3];
    assign crow     = yy[9:4];
    assign frow     = yy[3:0];
    assign in_win_o = in_x && in_y;

    // crow*80 as crow*64 + crow*16
    assign cell_idx    = {3'b000, crow, 6'b000000} + {5'b00000, crow, 4'b0000} + {8'h00, col};
    assign char_addr_o = TEXT_BASE + {cell_idx, 1'b0};
    assign font_addr_o = FONT_BASE + {4'h0, char_i, frow};

endmodule

// File: rtl/vram_text_scheduler.sv
// Arbitrates the single-port VRAM between the text-mode cell fetch and a CPU req/ack port.
module vram_text_scheduler
    import vga_text_pkg::*;
(
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic [9:0]  X,
    input  logic [9:0]  Y,
    input  logic        CPU_REQ,
    input  logic        CPU_WE,
    input  logic [15:0] CPU_ADDR,
    input  logic [7:0]  CPU_WDATA,
    output logic        CPU_ACK,
    output logic [7:0]  CPU_RDATA,
    output logic [15:0] VRAM_ADDR,
    output logic        VRAM_WE,
    output logic [7:0]  VRAM_WDATA,
    input  logic [7:0]  VRAM_RDATA,
    output logic [7:0]  PIX_CHAR,
    output logic [7:0]  PIX_ATTR,
    output logic [7:0]  PIX_FONT,
    output logic        PIX_VALID
);

    logic         win_n;
    logic [2:0]   phase_n;
    logic [15:0]  char_addr;
    logic [15:0]  font_addr;
    logic         grant_d;
    logic         pix_load;

    logic         win_q;
    fetch_phase_e phase_q;
    logic         grant_q;
    logic         ack_q;
    logic         cell_ok_q;
    logic [15:0]  vram_addr_q;
    logic         vram_we_q;
    logic [7:0]   vram_wdata_q;
    logic [7:0]   char_q;
    logic [7:0]   attr_q;
    logic [7:0]   font_q;
    logic [7:0]   pix_char_q;
    logic [7:0]   pix_attr_q;
    logic [7:0]   pix_font_q;
    logic         pix_valid_q;

    // The font address is formed while the char byte is still on VRAM_RDATA.
    text_addr_gen u_addr_gen (
        .x_i         (X),
        .y_i         (Y),
        .char_i      (VRAM_RDATA),
        .in_win_o    (win_n),
        .phase_o     (phase_n),
        .char_addr_o (char_addr),
        .font_addr_o (font_addr)
    );

    // REQ seen during the grant or ack cycle belongs to the access in flight.
    always_comb begin
        grant_d  = cpu_slot(win_n, phase_n) && CPU_REQ && !grant_q && !ack_q;
        pix_load = win_q && (phase_q == PH_CPU3) && cell_ok_q;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            win_q        <= 1'b0;
            phase_q      <= PH_CHAR;
            grant_q      <= 1'b0;
            ack_q        <= 1'b0;
            cell_ok_q    <= 1'b0;
            vram_addr_q  <= 16'h0000;
            vram_we_q    <= 1'b0;
            vram_wdata_q <= 8'h00;
            char_q       <= 8'h00;
            attr_q       <= 8'h00;
            font_q       <= 8'h00;
            pix_char_q   <= 8'h00;
            pix_attr_q   <= 8'h00;
            pix_font_q   <= 8'h00;
            pix_valid_q  <= 1'b0;
        end else begin
            win_q     <= win_n;
            phase_q   <= fetch_phase_e'(phase_n);
            grant_q   <= grant_d;
            ack_q     <= grant_q;
            vram_we_q <= grant_d && CPU_WE;

            if (grant_d) begin
                vram_addr_q  <= CPU_ADDR;
                vram_wdata_q <= CPU_WDATA;
            end else if (win_n) begin
                case (phase_n)
                    PH_CHAR: vram_addr_q <= char_addr;
                    PH_ATTR: vram_addr_q <= char_addr + 16'd1;
                    PH_FONT: vram_addr_q <= font_addr;
                    default: ;
                endcase
            end

            // Read data trails its address slot by one cycle.
            if (win_q) begin
                case (phase_q)
                    PH_ATTR:  char_q <= VRAM_RDATA;
                    PH_FONT:  attr_q <= VRAM_RDATA;
                    PH_LATCH: font_q <= VRAM_RDATA;
                    default:  ;
                endcase
            end

            if (win_n && (phase_n == PH_CHAR)) begin
                cell_ok_q <= 1'b1;
            end else if (pix_load) begin
                cell_ok_q <= 1'b0;
            end

            pix_valid_q <= pix_load;
            if (pix_load) begin
                pix_char_q <= char_q;
                pix_attr_q <= attr_q;
                pix_font_q <= font_q;
            end
        end
    end

    assign CPU_ACK    = ack_q;
    assign CPU_RDATA  = ack_q ? VRAM_RDATA : 8'h00;
    assign VRAM_ADDR  = vram_addr_q;
    assign VRAM_WE    = vram_we_q;
    assign VRAM_WDATA = vram_wdata_q;
    assign PIX_CHAR   = pix_char_q;
    assign PIX_ATTR   = pix_attr_q;
    assign PIX_FONT   = pix_font_q;
    assign PIX_VALID  = pix_valid_q;

endmodule
